mux_scan: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer with a valid/ready output handshake. Successor to the team's 4:1 single-bit combinational mux.
- Two modes:
  - Manual: an external selector picks the channel.
  - Auto: a round-robin scanner steps through the channels and forwards only those holding valid data.
- Sits between parallel sensor/data sources and a single downstream consumer.

---
 rtl/mux_scan.sv | 166 ++++++++++++++++
 tb/tb_mux_scan.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// mux_scan: N-channel W-bit registered mux; manual selector or round-robin scan of valid channels.
// 1-cycle capture latency, output held under backpressure; `define MUX_SEL_ERR_EN adds sticky sel_err.
module mux_scan #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [SEL_W-1:0]          selector,
  input  logic                      auto_mode,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [SEL_W-1:0]          chan_out
`ifdef MUX_SEL_ERR_EN
  ,
  output logic                      sel_err
`endif
);

  localparam int                 SLOTS  = 1 << SEL_W;
  localparam logic [SEL_W:0]     CHAN_N = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0]   LAST   = SEL_W'(CHANNELS - 1);

  typedef enum logic {
    S_MAN  = 1'b0,
    S_AUTO = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic [SEL_W-1:0] chan_q, chan_d;

  logic             load_ok;
  logic             sel_in_rng;
  logic             cap;
  logic [SEL_W-1:0] c_idx;

  // Channel views padded to the full selector range so any index is safe; pad slots read as invalid.
  logic [SLOTS-1:0] vld_ext;
  logic [WIDTH-1:0] dat_ext [SLOTS];

  assign vld_ext = SLOTS'(in_valid);

  for (genvar k = 0; k < SLOTS; k++) begin : g_dat
    if (k < CHANNELS) begin : g_real
      assign dat_ext[k] = din[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign dat_ext[k] = '0;
    end
  end

  assign load_ok    = !vld_q || dout_ready;
  assign sel_in_rng = {1'b0, selector} < CHAN_N;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_MAN;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_MAN:   if (auto_mode)  state_d = S_AUTO;
      S_AUTO:  if (!auto_mode) state_d = S_MAN;
      default: state_d = S_MAN;
    endcase
  end

  // Entering auto costs one dead cycle: ptr is cleared and nothing is captured.
  always_comb begin
    c_idx = selector;
    cap   = 1'b0;
    ptr_d = ptr_q;
    unique case (state_q)
      S_MAN: begin
        c_idx = selector;
        cap   = load_ok && sel_in_rng && vld_ext[selector] && !auto_mode;
        if (auto_mode) ptr_d = '0;
      end
      S_AUTO: begin
        c_idx = ptr_q;
        cap   = load_ok && vld_ext[ptr_q];
        if (load_ok) ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
      end
      default: begin
        c_idx = selector;
        cap   = 1'b0;
      end
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    chan_d = chan_q;
    vld_d  = vld_q;
    if (cap) begin
      dout_d = dat_ext[c_idx];
      chan_d = c_idx;
      vld_d  = 1'b1;
    end else if (load_ok) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      chan_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      chan_q <= chan_d;
      vld_q  <= vld_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign chan_out   = chan_q;

`ifdef MUX_SEL_ERR_EN
  logic sel_err_q, sel_err_d;
  logic cap_try;
  logic x_hit;

  assign cap_try = load_ok && ((state_q == S_AUTO) || (sel_in_rng && !auto_mode));

`ifndef SYNTHESIS
  // An unknown valid bit on a channel we are about to sample is flagged in simulation only.
  assign x_hit = cap_try && $isunknown(vld_ext[c_idx]);

  always_ff @(posedge clk) begin
    if (!rst && cap_try) begin
      assert (!$isunknown(vld_ext[c_idx]));
    end
  end
`else
  assign x_hit = 1'b0;
`endif

  always_comb begin
    sel_err_d = sel_err_q;
    if ((state_q == S_MAN) && load_ok && !sel_in_rng) sel_err_d = 1'b1;
    if (x_hit) sel_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: a 4-channel instance for the main flow and a 3-channel instance
// for the out-of-range selector case.
module tb_mux_scan;

  logic        clk;
  logic        rst;

  logic [31:0] din;
  logic [3:0]  in_valid;
  logic [1:0]  selector;
  logic        auto_mode;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [1:0]  chan_out;

  logic [23:0] din3;
  logic [2:0]  in_valid3;
  logic [1:0]  selector3;
  logic        auto_mode3;
  logic [7:0]  dout3;
  logic        dout_valid3;
  logic        dout_ready3;
  logic [1:0]  chan_out3;

`ifdef MUX_SEL_ERR_EN
  logic        sel_err;
  logic        sel_err3;
`endif

  int checks = 0;
  int errors = 0;

  mux_scan #(.CHANNELS(4), .WIDTH(8), .SEL_W(2)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .in_valid   (in_valid),
    .selector   (selector),
    .auto_mode  (auto_mode),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .chan_out   (chan_out)
`ifdef MUX_SEL_ERR_EN
    ,
    .sel_err    (sel_err)
`endif
  );

  mux_scan #(.CHANNELS(3), .WIDTH(8), .SEL_W(2)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .din        (din3),
    .in_valid   (in_valid3),
    .selector   (selector3),
    .auto_mode  (auto_mode3),
    .dout       (dout3),
    .dout_valid (dout_valid3),
    .dout_ready (dout_ready3),
    .chan_out   (chan_out3)
`ifdef MUX_SEL_ERR_EN
    ,
    .sel_err    (sel_err3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    auto_mode   = 1'b0;
    selector    = 2'd1;
    din         = 32'hFFFF_FFFF;
    in_valid    = 4'hF;
    dout_ready  = 1'b1;
    din3        = 24'h33_22_11;
    in_valid3   = 3'b111;
    selector3   = 2'd3;
    auto_mode3  = 1'b0;
    dout_ready3 = 1'b1;

    // Reset held two cycles with every input active
    step();
    step();
    check("rst_dout", dout, 8'h00);
    check("rst_vld", dout_valid, 1'b0);
    check("rst_chan", chan_out, 2'd0);
    check("rst_vld3", dout_valid3, 1'b0);

    // Manual capture of ch2
    rst      = 1'b0;
    selector = 2'd2;
    din      = 32'h00_A5_00_00;
    in_valid = 4'b0100;
    step();
    check("man_dout", dout, 8'hA5);
    check("man_vld", dout_valid, 1'b1);
    check("man_chan", chan_out, 2'd2);
    check("oor_vld3", dout_valid3, 1'b0);
`ifdef MUX_SEL_ERR_EN
    check("oor_selerr3", sel_err3, 1'b1);
`endif

    // Backpressure: ch2 changes but A5 must hold
    dout_ready = 1'b0;
    din        = 32'h00_3C_00_00;
    selector3  = 2'd0;
    step();
    check("bp1_dout", dout, 8'hA5);
    check("bp1_vld", dout_valid, 1'b1);
    check("d3_sel0_dout", dout3, 8'h11);
    check("d3_sel0_chan", chan_out3, 2'd0);
`ifdef MUX_SEL_ERR_EN
    check("selerr3_sticky", sel_err3, 1'b1);
`endif
    step();
    check("bp2_dout", dout, 8'hA5);
    check("bp2_chan", chan_out, 2'd2);
    step();
    check("bp3_dout", dout, 8'hA5);
    dout_ready = 1'b1;
    step();
    check("bp_refill_dout", dout, 8'h3C);
    check("bp_refill_vld", dout_valid, 1'b1);

    // Consume without refill keeps data/channel
    in_valid = 4'b0000;
    step();
    check("drain_vld", dout_valid, 1'b0);
    check("drain_dout", dout, 8'h3C);
    check("drain_chan", chan_out, 2'd2);

    selector = 2'd0;
    in_valid = 4'b0001;
    din      = 32'h00_00_00_5A;
    step();
    check("man0_dout", dout, 8'h5A);
    check("man0_chan", chan_out, 2'd0);

    // Auto scan over 1011: 11, 22, bubble, 44, 11 (wrap), 22
    din       = 32'h44_33_22_11;
    in_valid  = 4'b1011;
    auto_mode = 1'b1;
    step();
    check("auto_entry_vld", dout_valid, 1'b0);
    check("auto_entry_dout", dout, 8'h5A);
    step();
    check("auto_c0_dout", dout, 8'h11);
    check("auto_c0_chan", chan_out, 2'd0);
    step();
    check("auto_c1_dout", dout, 8'h22);
    check("auto_c1_chan", chan_out, 2'd1);
    step();
    check("auto_skip2_vld", dout_valid, 1'b0);
    step();
    check("auto_c3_dout", dout, 8'h44);
    check("auto_c3_chan", chan_out, 2'd3);
    step();
    check("auto_wrap_dout", dout, 8'h11);
    check("auto_wrap_chan", chan_out, 2'd0);
    step();
    check("auto_c1b_dout", dout, 8'h22);

    // Drop auto_mode while stalled; ch1 sample survives, then selector 3 resumes
    dout_ready = 1'b0;
    auto_mode  = 1'b0;
    selector   = 2'd3;
    step();
    check("sw_hold1_dout", dout, 8'h22);
    check("sw_hold1_chan", chan_out, 2'd1);
    step();
    check("sw_hold2_vld", dout_valid, 1'b1);
    check("sw_hold2_dout", dout, 8'h22);
    dout_ready = 1'b1;
    step();
    check("sw_man_dout", dout, 8'h44);
    check("sw_man_chan", chan_out, 2'd3);

    // Reset mid-operation in auto with ptr at 2
    auto_mode = 1'b1;
    step();
    check("re_entry_vld", dout_valid, 1'b0);
    step();
    check("re_c0_dout", dout, 8'h11);
    step();
    check("re_c1_dout", dout, 8'h22);
    check("re_c1_vld", dout_valid, 1'b1);
    rst = 1'b1;
    step();
    check("mid_rst_vld", dout_valid, 1'b0);
    check("mid_rst_dout", dout, 8'h00);
    check("mid_rst_chan", chan_out, 2'd0);
    rst = 1'b0;
    step();
    check("post_rst_man_vld", dout_valid, 1'b0);
    step();
    check("post_rst_c0_dout", dout, 8'h11);
    check("post_rst_c0_chan", chan_out, 2'd0);
`ifdef MUX_SEL_ERR_EN
    check("selerr_main", sel_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
